// File: rtl/decode_stage_if.sv
// Fetch/execute/writeback handshake bundle for decode_stage.
// Carries out_mext only when DECODE_MEXT_EN is defined.
interface decode_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [6:0]      out_opcode;
    logic [2:0]      out_funct3;
    logic            out_op_switch;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic            out_we;
    logic [XLEN-1:0] out_imm;
    logic [XLEN-1:0] out_pc;
    logic            out_illegal;
`ifdef DECODE_MEXT_EN
    logic            out_mext;
`endif
    logic            wb_valid;
    logic [4:0]      wb_addr;

    modport master (
`ifdef DECODE_MEXT_EN
        input  out_mext,
`endif
        output in_valid, in_instr, in_pc, flush,
        output out_ready, wb_valid, wb_addr,
        input  in_ready, out_valid, out_opcode, out_funct3,
        input  out_op_switch, out_rs1, out_rs2, out_rd,
        input  out_we, out_imm, out_pc, out_illegal
    );

    modport slave (
`ifdef DECODE_MEXT_EN
        output out_mext,
`endif
        input  in_valid, in_instr, in_pc, flush,
        input  out_ready, wb_valid, wb_addr,
        output in_ready, out_valid, out_opcode, out_funct3,
        output out_op_switch, out_rs1, out_rs2, out_rd,
        output out_we, out_imm, out_pc, out_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// Registered RV32I decode stage with busy-register scoreboard and flush.
// Defining DECODE_MEXT_EN accepts funct7=0000001 ALU ops and drives out_mext.
module decode_stage #(
    parameter int XLEN      = 32,
    parameter int NREG      = 32,
    parameter int WB_BYPASS = 1
) (
    input logic           clk,
    input logic           rst_n,
    decode_stage_if.slave bus
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_ALU    = 7'b0110011;

    logic [31:0] ins;
    logic [6:0]  opc;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;

    assign ins = bus.in_instr;
    assign opc = ins[6:0];
    assign f3  = ins[14:12];
    assign f7  = ins[31:25];
    assign rs1 = ins[19:15];
    assign rs2 = ins[24:20];
    assign rd  = ins[11:7];

    logic is_lui, is_auipc, is_jal, is_jalr, is_branch;
    logic is_load, is_store, is_alui, is_alu;

    assign is_lui    = opc == OP_LUI;
    assign is_auipc  = opc == OP_AUIPC;
    assign is_jal    = opc == OP_JAL;
    assign is_jalr   = opc == OP_JALR;
    assign is_branch = opc == OP_BRANCH;
    assign is_load   = opc == OP_LOAD;
    assign is_store  = opc == OP_STORE;
    assign is_alui   = opc == OP_ALUI;
    assign is_alu    = opc == OP_ALU;

    logic known;
    logic alu_bad;
    logic illegal;
    logic writes;
    logic we;
    logic use1;
    logic use2;
    logic op_switch;
    logic mext;

    assign known = is_lui | is_auipc | is_jal | is_jalr | is_branch
                 | is_load | is_store | is_alui | is_alu;

    always_comb begin
        alu_bad = 1'b0;
        if (is_alu) begin
            unique case (f7)
                7'b0000000: alu_bad = 1'b0;
                7'b0100000: alu_bad = !(f3 == 3'b000 || f3 == 3'b101);
`ifdef DECODE_MEXT_EN
                7'b0000001: alu_bad = 1'b0;
`endif
                default:    alu_bad = 1'b1;
            endcase
        end
    end

    assign illegal = !known | alu_bad;
    assign writes  = is_lui | is_auipc | is_jal | is_jalr
                   | is_load | is_alui | is_alu;
    assign we      = writes & (rd != 5'd0) & !illegal;
    assign use1    = is_jalr | is_branch | is_load | is_store
                   | is_alui | is_alu;
    assign use2    = is_branch | is_store | is_alu;

    assign op_switch =
        (is_alu & ins[30] & (f3 == 3'b000 || f3 == 3'b101)) |
        (is_alui & ins[30] & (f3 == 3'b101));

`ifdef DECODE_MEXT_EN
    assign mext = is_alu & (f7 == 7'b0000001);
`else
    assign mext = 1'b0;
`endif

    logic [31:0]     imm32;
    logic [XLEN-1:0] imm;

    always_comb begin
        imm32 = '0;
        unique case (1'b1)
            is_lui | is_auipc:
                imm32 = {ins[31:12], 12'b0};
            is_jal:
                imm32 = {{12{ins[31]}}, ins[19:12], ins[20],
                         ins[30:21], 1'b0};
            is_jalr | is_load | is_alui:
                imm32 = {{20{ins[31]}}, ins[31:20]};
            is_store:
                imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            is_branch:
                imm32 = {{20{ins[31]}}, ins[7], ins[30:25],
                         ins[11:8], 1'b0};
            default:
                imm32 = '0;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

    logic [NREG-1:0] busy;
    logic [NREG-1:0] clr;
    logic [NREG-1:0] busy_eff;

    always_comb begin
        clr = '0;
        for (int i = 1; i < NREG; i++)
            clr[i] = bus.wb_valid && (bus.wb_addr == 5'(i));
    end

    // With bypass, a register retiring this cycle no longer blocks.
    assign busy_eff = (WB_BYPASS != 0) ? (busy & ~clr) : busy;

    function automatic logic hit(input logic [NREG-1:0] v,
                                 input logic [4:0] a);
        logic r;
        r = 1'b0;
        for (int i = 1; i < NREG; i++)
            if (a == 5'(i)) r = v[i];
        return r;
    endfunction

    logic            valid_q;
    logic [6:0]      opc_q;
    logic [2:0]      f3_q;
    logic            opsw_q;
    logic [4:0]      rs1_q;
    logic [4:0]      rs2_q;
    logic [4:0]      rd_q;
    logic            we_q;
    logic [XLEN-1:0] imm_q;
    logic [XLEN-1:0] pc_q;
    logic            ill_q;
    logic            mext_q;

    logic held1, held2, heldd;
    logic hazard;
    logic ready;
    logic accept;
    logic fire;

    assign held1 = valid_q & we_q & (rs1 == rd_q);
    assign held2 = valid_q & we_q & (rs2 == rd_q);
    assign heldd = valid_q & we_q & (rd == rd_q);

    assign hazard =
        (use1 & (rs1 != 5'd0) & (hit(busy_eff, rs1) | held1)) |
        (use2 & (rs2 != 5'd0) & (hit(busy_eff, rs2) | held2)) |
        (we & (hit(busy_eff, rd) | heldd));

    assign ready  = !bus.flush & !hazard & (!valid_q | bus.out_ready);
    assign accept = bus.in_valid & ready;
    assign fire   = valid_q & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            opc_q   <= '0;
            f3_q    <= '0;
            opsw_q  <= 1'b0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            we_q    <= 1'b0;
            imm_q   <= '0;
            pc_q    <= '0;
            ill_q   <= 1'b0;
            mext_q  <= 1'b0;
        end else if (bus.flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            opc_q   <= opc;
            f3_q    <= f3;
            opsw_q  <= op_switch;
            rs1_q   <= rs1;
            rs2_q   <= rs2;
            rd_q    <= rd;
            we_q    <= we;
            imm_q   <= imm;
            pc_q    <= bus.in_pc;
            ill_q   <= illegal;
            mext_q  <= mext;
        end else if (fire) begin
            valid_q <= 1'b0;
        end
    end

    // A fired bundle reaches execute, so it sets busy even under flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy[0] <= 1'b0;
            for (int i = 1; i < NREG; i++) begin
                if (fire && we_q && rd_q == 5'(i))
                    busy[i] <= 1'b1;
                else if (clr[i])
                    busy[i] <= 1'b0;
            end
        end
    end

    assign bus.in_ready      = ready;
    assign bus.out_valid     = valid_q;
    assign bus.out_opcode    = opc_q;
    assign bus.out_funct3    = f3_q;
    assign bus.out_op_switch = opsw_q;
    assign bus.out_rs1       = rs1_q;
    assign bus.out_rs2       = rs2_q;
    assign bus.out_rd        = rd_q;
    assign bus.out_we        = we_q;
    assign bus.out_imm       = imm_q;
    assign bus.out_pc        = pc_q;
    assign bus.out_illegal   = ill_q;
`ifdef DECODE_MEXT_EN
    assign bus.out_mext      = mext_q;
`else
    logic unused_mext;
    assign unused_mext = mext_q;
`endif
endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected bundles queued at accept,
// popped and compared when execute takes them.
module tb_decode_stage;
    logic clk;
    logic rst_n;

    decode_stage_if #(.XLEN(32)) bus ();

    decode_stage #(.XLEN(32), .NREG(32), .WB_BYPASS(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DECODE_MEXT_EN
    localparam logic MX = 1'b1;
`else
    localparam logic MX = 1'b0;
`endif

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        we;
        logic [31:0] imm;
        logic        opsw;
        logic        ill;
        logic        mx;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    int          total;
    int          bad;
    logic        last_acc;
    logic        last_rdy;
    logic [31:0] pc_ctr;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cmp(input exp_t e);
        check("opcode", 64'(bus.out_opcode), 64'(e.instr[6:0]));
        check("funct3", 64'(bus.out_funct3), 64'(e.instr[14:12]));
        check("rs1", 64'(bus.out_rs1), 64'(e.instr[19:15]));
        check("rs2", 64'(bus.out_rs2), 64'(e.instr[24:20]));
        check("rd", 64'(bus.out_rd), 64'(e.instr[11:7]));
        check("we", 64'(bus.out_we), 64'(e.we));
        check("imm", 64'(bus.out_imm), 64'(e.imm));
        check("pc", 64'(bus.out_pc), 64'(e.pc));
        check("opsw", 64'(bus.out_op_switch), 64'(e.opsw));
        check("illegal", 64'(bus.out_illegal), 64'(e.ill));
`ifdef DECODE_MEXT_EN
        check("mext", 64'(bus.out_mext), 64'(e.mx));
`endif
    endtask

    task automatic cyc();
        exp_t e;
        @(negedge clk);
        last_rdy = bus.in_ready;
        last_acc = bus.in_valid && bus.in_ready;
        if (bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                check("spurious_out", 64'd1, 64'd0);
            end else begin
                e = q.pop_front();
                cmp(e);
            end
        end else if (bus.flush) begin
            q.delete();
        end
        if (last_acc) q.push_back(cur);
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [31:0] ins, input logic we,
                          input logic [31:0] imm, input logic opsw,
                          input logic ill, input logic mx);
        cur.instr = ins;
        cur.pc    = pc_ctr;
        cur.we    = we;
        cur.imm   = imm;
        cur.opsw  = opsw;
        cur.ill   = ill;
        cur.mx    = mx;
        bus.in_valid = 1'b1;
        bus.in_instr = ins;
        bus.in_pc    = pc_ctr;
        pc_ctr       = pc_ctr + 32'd4;
    endtask

    task automatic send(input logic [31:0] ins, input logic we,
                        input logic [31:0] imm, input logic opsw,
                        input logic ill, input logic mx);
        set_in(ins, we, imm, opsw, ill, mx);
        for (int n = 0; n < 20; n++) begin
            cyc();
            if (last_acc) break;
        end
        bus.in_valid = 1'b0;
        if (!last_acc) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic wb(input logic [4:0] a);
        bus.wb_valid = 1'b1;
        bus.wb_addr  = a;
        cyc();
        bus.wb_valid = 1'b0;
        bus.wb_addr  = '0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        pc_ctr = 32'h1000;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.in_pc     = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        bus.wb_valid  = 1'b0;
        bus.wb_addr   = '0;
        #3;
        check("rst_ov", 64'(bus.out_valid), 64'd0);
        check("rst_rd", 64'(bus.out_rd), 64'd0);
        check("rst_imm", 64'(bus.out_imm), 64'd0);
        check("rst_busy", 64'(dut.busy), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc();

        // addi then dependent add: stall until x1 retires
        send(32'h00500093, 1, 32'd5, 0, 0, 0);
        check("lat_ov", 64'(bus.out_valid), 64'd1);
        set_in(32'h00108133, 1, 32'd0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("raw_stall", 64'(last_acc), 64'd0);
        end
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 5'd1;
        cyc();
        check("wb_bypass", 64'(last_acc), 64'd1);
        bus.wb_valid = 1'b0;
        bus.in_valid = 1'b0;
        cyc();
        cyc();
        wb(5'd2);

        send(32'h407302B3, 1, 32'd0, 1, 0, 0);
        send(32'hFE000EE3, 0, 32'hFFFFFFFC, 0, 0, 0);
        send(32'h123451B7, 1, 32'h12345000, 0, 0, 0);
        send(32'h00112423, 0, 32'd8, 0, 0, 0);
        send(32'hFE002E23, 0, 32'hFFFFFFFC, 0, 0, 0);
        send(32'hFF9FF06F, 0, 32'hFFFFFFF8, 0, 0, 0);
        send(32'h40335313, 1, 32'h00000403, 1, 0, 0);
        send(32'hFFF0A383, 1, 32'hFFFFFFFF, 0, 0, 0);
        send(32'hFFFFF217, 1, 32'hFFFFF000, 0, 0, 0);
        cyc();
        cyc();
        wb(5'd4);
        wb(5'd5);
        wb(5'd6);
        wb(5'd7);

        // WAW on x3 until it retires
        set_in(32'h00700193, 1, 32'd7, 0, 0, 0);
        cyc();
        check("waw_stall", 64'(last_acc), 64'd0);
        bus.wb_valid = 1'b1;
        bus.wb_addr  = 5'd3;
        cyc();
        check("waw_release", 64'(last_acc), 64'd1);
        bus.wb_valid = 1'b0;
        bus.in_valid = 1'b0;
        cyc();
        cyc();
        wb(5'd3);
        check("busy_clear", 64'(dut.busy), 64'd0);

        send(32'h00000000, 0, 32'd0, 0, 1, 0);
        send(32'h000000FF, 0, 32'd0, 0, 1, 0);
        send(32'h40209033, 0, 32'd0, 0, 1, 0);
        send(32'h02208033, 0, 32'd0, 0, !MX, MX);
        cyc();
        cyc();
        check("ill_nobusy", 64'(dut.busy), 64'd0);

        // hold three cycles, flush in the second
        bus.out_ready = 1'b0;
        send(32'h00100413, 1, 32'd1, 0, 0, 0);
        set_in(32'h00200493, 1, 32'd2, 0, 0, 0);
        cyc();
        check("hold_rdy", 64'(last_rdy), 64'd0);
        check("hold_ov", 64'(bus.out_valid), 64'd1);
        check("hold_rd", 64'(bus.out_rd), 64'd8);
        check("hold_imm", 64'(bus.out_imm), 64'd1);
        bus.flush = 1'b1;
        cyc();
        check("flush_rdy", 64'(last_rdy), 64'd0);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_ov", 64'(bus.out_valid), 64'd0);
        cyc();
        check("flush_busy", 64'(dut.busy), 64'd0);
        bus.out_ready = 1'b1;
        cyc();

        // async reset mid-stall with x1 busy
        send(32'h00500093, 1, 32'd5, 0, 0, 0);
        cyc();
        bus.out_ready = 1'b0;
        send(32'h123451B7, 1, 32'h12345000, 0, 0, 0);
        set_in(32'h00108133, 1, 32'd0, 0, 0, 0);
        cyc();
        check("rs_stall", 64'(last_acc), 64'd0);
        check("rs_busy1", 64'(dut.busy[1]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rs_ov", 64'(bus.out_valid), 64'd0);
        check("rs_rd", 64'(bus.out_rd), 64'd0);
        check("rs_busy", 64'(dut.busy), 64'd0);
        rst_n = 1'b1;
        q.delete();
        bus.out_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            cyc();
            if (last_acc) break;
        end
        check("rs_accept", 64'(last_acc), 64'd1);
        bus.in_valid = 1'b0;
        cyc();
        cyc();
        check("q_empty", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
